// File: rtl/mem_proto_pkg.sv
// Shared encodings for the three-channel memory-source protocol:
// channel FSM states, target codes, burst limit and beat widths.
package mem_proto_pkg;

    typedef enum logic [1:0] {
        CH_IDLE  = 2'd0,
        CH_WAIT  = 2'd1,
        CH_DRIVE = 2'd2,
        CH_GAP   = 2'd3
    } chan_state_t;

    localparam logic [1:0] TGT_SDRAM = 2'd0;
    localparam logic [1:0] TGT_FLASH = 2'd1;
    localparam logic [1:0] TGT_ROM   = 2'd2;
    localparam logic [1:0] TGT_ALL   = 2'd3;

    localparam int MAX_LEN_DEF = 5;
    localparam int SDRAM_W     = 2;
    localparam int FLASH_W     = 4;
    localparam int ROM_W       = 1;

    function automatic logic [2:0] clamp_len(input logic [2:0] len, input int max_len);
        return (int'(len) > max_len) ? 3'(max_len) : len;
    endfunction

endpackage

// File: rtl/mem_req_chan.sv
// One channel FSM: waits for start, drives len valid beats, idles for a gap,
// and aborts back to IDLE if start never arrives within the timeout.
module mem_req_chan
    import mem_proto_pkg::*;
#(
    parameter int GAP_CYCLES   = 1,
    parameter int WAIT_TIMEOUT = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        launch,
    input  logic        start,
    input  logic [2:0]  len,
    output chan_state_t state,
    output logic        valid,
    output logic [2:0]  beat,
    output logic        last_gap,
    output logic        timeout
);

    localparam int WW = $clog2(WAIT_TIMEOUT + 1);

    chan_state_t   state_nx;
    logic [2:0]    beat_cnt;
    logic [1:0]    gap_cnt;
    logic [WW-1:0] wait_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= CH_IDLE;
            beat_cnt <= '0;
            gap_cnt  <= '0;
            wait_cnt <= '0;
        end else begin
            state    <= state_nx;
            beat_cnt <= (state == CH_DRIVE) ? beat_cnt + 3'd1 : 3'd0;
            gap_cnt  <= (state == CH_GAP) ? gap_cnt + 2'd1 : 2'd0;
            wait_cnt <= (state == CH_WAIT && !start) ? wait_cnt + WW'(1) : '0;
        end
    end

    always_comb begin
        state_nx = state;
        last_gap = 1'b0;
        timeout  = 1'b0;
        case (state)
            CH_IDLE: begin
                if (launch) state_nx = CH_WAIT;
            end
            CH_WAIT: begin
                if (start) begin
                    state_nx = CH_DRIVE;
                end else if (wait_cnt == WW'(WAIT_TIMEOUT - 1)) begin
                    timeout  = 1'b1;
                    state_nx = CH_IDLE;
                end
            end
            CH_DRIVE: begin
                if (beat_cnt == len - 3'd1) state_nx = CH_GAP;
            end
            CH_GAP: begin
                last_gap = (gap_cnt == 2'(GAP_CYCLES - 1));
                if (last_gap) state_nx = CH_IDLE;
            end
            default: state_nx = CH_IDLE;
        endcase
    end

    assign valid = (state == CH_DRIVE);
    assign beat  = beat_cnt;

endmodule

// File: rtl/saturating_counter.sv
// Up-counter that sticks at its all-ones value until reset.
module saturating_counter #(
    parameter int WIDTH = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/mem_req_gen.sv
// Command-driven initiator for the sdram/flash/rom memory-source channels,
// with multicast lockstep start and per-channel FSM toggle coverage.
module mem_req_gen
    import mem_proto_pkg::*;
#(
    parameter int MAX_LEN      = MAX_LEN_DEF,
    parameter int GAP_CYCLES   = 1,
    parameter int WAIT_TIMEOUT = 15
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_target,
    input  logic [3:0]         cmd_data,
    input  logic [2:0]         cmd_len,
    input  logic               sdram_ready,
    output logic               sdram_valid,
    output logic [SDRAM_W-1:0] sdram_data_o,
    input  logic               flash_ready,
    output logic               flash_valid,
    output logic [FLASH_W-1:0] flash_data_o,
    input  logic               rom_ready,
    output logic               rom_valid,
    output logic [ROM_W-1:0]   rom_data_o,
    output logic               done,
    output logic               err,
    output logic [11:0]        coverage
);

    // Command handshake: a command moves on an edge where cmd_valid && cmd_ready;
    // cmd_ready holds only while every channel is IDLE and no done/err is owed.

    logic [1:0]  tgt_q;
    logic [3:0]  data_q;
    logic [2:0]  len_q;
    logic        zero_done_q;
    logic        err_q;
    logic        accept;
    logic        all_ready;
    logic [2:0]  len_c;
    logic [2:0]  launch;
    logic [2:0]  start;
    logic [2:0]  valid;
    logic [2:0]  last_gap;
    logic [2:0]  timeout;
    logic [2:0]  chan_beat [3];
    chan_state_t st [3];
    logic [1:0]  rom_idx;
    logic [11:0] ind;
    logic [11:0] ind_q;
    logic [11:0] toggle;

    assign len_c     = clamp_len(cmd_len, MAX_LEN);
    assign cmd_ready = (st[0] == CH_IDLE) && (st[1] == CH_IDLE) && (st[2] == CH_IDLE)
                       && !zero_done_q && !err_q;
    assign accept    = cmd_valid && cmd_ready;
    assign all_ready = sdram_ready && flash_ready && rom_ready;

    always_comb begin
        launch = '0;
        if (accept && (len_c != 3'd0)) begin
            launch[0] = (cmd_target == TGT_SDRAM) || (cmd_target == TGT_ALL);
            launch[1] = (cmd_target == TGT_FLASH) || (cmd_target == TGT_ALL);
            launch[2] = (cmd_target == TGT_ROM)   || (cmd_target == TGT_ALL);
        end
    end

    // A shared start keeps multicast channels cycle-aligned.
    assign start[0] = (tgt_q == TGT_ALL) ? all_ready : sdram_ready;
    assign start[1] = (tgt_q == TGT_ALL) ? all_ready : flash_ready;
    assign start[2] = (tgt_q == TGT_ALL) ? all_ready : rom_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            tgt_q       <= TGT_SDRAM;
            data_q      <= '0;
            len_q       <= '0;
            zero_done_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            zero_done_q <= accept && (len_c == 3'd0);
            err_q       <= |timeout;
            if (accept) begin
                tgt_q  <= cmd_target;
                data_q <= cmd_data;
                len_q  <= len_c;
            end
        end
    end

    for (genvar i = 0; i < 3; i++) begin : g_chan
        mem_req_chan #(
            .GAP_CYCLES   (GAP_CYCLES),
            .WAIT_TIMEOUT (WAIT_TIMEOUT)
        ) u_chan (
            .clock    (clock),
            .reset    (reset),
            .launch   (launch[i]),
            .start    (start[i]),
            .len      (len_q),
            .state    (st[i]),
            .valid    (valid[i]),
            .beat     (chan_beat[i]),
            .last_gap (last_gap[i]),
            .timeout  (timeout[i])
        );
    end

    assign done = zero_done_q || (|last_gap);
    assign err  = err_q;

    assign sdram_valid = valid[0];
    assign flash_valid = valid[1];
    assign rom_valid   = valid[2];

    assign rom_idx = (chan_beat[2] > 3'd3) ? 2'd3 : chan_beat[2][1:0];

    assign sdram_data_o = !valid[0] ? 2'b00 :
                          (chan_beat[0] == 3'd0) ? data_q[1:0] : data_q[3:2];
    assign flash_data_o = valid[1] ? data_q : 4'h0;
    assign rom_data_o   = valid[2] & data_q[rom_idx];

    always_comb begin
        ind = '0;
        for (int c = 0; c < 3; c++) begin
            ind[4*c +: 4] = {st[c] == CH_GAP, st[c] == CH_DRIVE, st[c] == CH_WAIT, st[c] == CH_IDLE};
        end
    end

    // Previous indicators reset to the all-IDLE pattern so reset itself is not a toggle.
    always_ff @(posedge clock) begin
        if (reset) begin
            ind_q <= 12'h111;
        end else begin
            ind_q <= ind;
        end
    end

    assign toggle = ind ^ ind_q;

    for (genvar b = 0; b < 12; b++) begin : g_cov
        saturating_counter #(.WIDTH(1)) u_cov (
            .clock (clock),
            .reset (reset),
            .inc   (toggle[b]),
            .count (coverage[b])
        );
    end

endmodule
